// File: rtl/riscv_decode_stage.sv
// ============================================================================
// Module   : riscv_decode_stage
// Brief    : Pipelined RV32I decoder with valid/ready handshake, illegal flag
//            and saturating illegal-instruction counter. Optional macro
//            RISCV_DECODE_SKID_EN adds a 2-entry skid buffer (registered ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_decode_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [2:0]           out_fmt,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_reg_write,
    output logic                 out_is_load,
    output logic                 out_is_store,
    output logic                 out_is_branch,
    output logic                 out_is_jal,
    output logic                 out_is_jalr,
    output logic                 out_alu_sub,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [2:0] c_fmt_r    = 3'd0;
    localparam logic [2:0] c_fmt_i    = 3'd1;
    localparam logic [2:0] c_fmt_s    = 3'd2;
    localparam logic [2:0] c_fmt_b    = 3'd3;
    localparam logic [2:0] c_fmt_u    = 3'd4;
    localparam logic [2:0] c_fmt_j    = 3'd5;
    localparam logic [2:0] c_fmt_none = 3'd7;

    localparam logic [6:0] c_f7_zero = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            alu_sub;
        logic            illegal;
    } dec_t;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_u;
    logic            w_legal;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_alu_sub;
    dec_t            w_dec;
    logic            w_accept;

    dec_t                 r_out;
    logic                 r_out_valid;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];

    assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_u = XLEN'({in_instr[31:12], 12'b0});

    // Opcodes all end in 2'b11, so a non-32-bit encoding falls into default.
    always_comb begin
        w_legal     = 1'b0;
        w_fmt       = c_fmt_none;
        w_imm       = '0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_alu_sub   = 1'b0;
        case (w_opcode)
            c_op_r: begin
                w_fmt     = c_fmt_r;
                w_legal   = (w_f7 == c_f7_zero) ||
                            ((w_f7 == c_f7_alt) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_alu_sub = (w_f3 == 3'b000) && (w_f7 == c_f7_alt);
            end
            c_op_imm: begin
                w_fmt = c_fmt_i;
                w_imm = w_imm_i;
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == c_f7_zero);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == c_f7_zero) || (w_f7 == c_f7_alt);
                else
                    w_legal = 1'b1;
            end
            c_op_load: begin
                w_fmt     = c_fmt_i;
                w_imm     = w_imm_i;
                w_is_load = 1'b1;
                w_legal   = !((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111));
            end
            c_op_store: begin
                w_fmt      = c_fmt_s;
                w_imm      = w_imm_s;
                w_is_store = 1'b1;
                w_legal    = (w_f3 < 3'b011);
            end
            c_op_branch: begin
                w_fmt       = c_fmt_b;
                w_imm       = w_imm_b;
                w_is_branch = 1'b1;
                w_legal     = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            c_op_jal: begin
                w_fmt    = c_fmt_j;
                w_imm    = w_imm_j;
                w_is_jal = 1'b1;
                w_legal  = 1'b1;
            end
            c_op_jalr: begin
                w_fmt     = c_fmt_i;
                w_imm     = w_imm_i;
                w_is_jalr = 1'b1;
                w_legal   = (w_f3 == 3'b000);
            end
            c_op_lui, c_op_auipc: begin
                w_fmt   = c_fmt_u;
                w_imm   = w_imm_u;
                w_legal = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase

        w_dec        = '0;
        w_dec.pc     = in_pc;
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = w_f3;
        w_dec.funct7 = w_f7;
        if (w_legal) begin
            w_dec.fmt       = w_fmt;
            w_dec.imm       = w_imm;
            w_dec.reg_write = (w_fmt != c_fmt_s) && (w_fmt != c_fmt_b) && (in_instr[11:7] != 5'd0);
            w_dec.is_load   = w_is_load;
            w_dec.is_store  = w_is_store;
            w_dec.is_branch = w_is_branch;
            w_dec.is_jal    = w_is_jal;
            w_dec.is_jalr   = w_is_jalr;
            w_dec.alu_sub   = w_alu_sub;
        end else begin
            w_dec.fmt     = c_fmt_none;
            w_dec.illegal = 1'b1;
        end
    end

    assign w_accept = in_valid & in_ready & ~flush;

`ifdef RISCV_DECODE_SKID_EN
    dec_t r_skid;
    logic r_skid_valid;
    logic r_in_ready;

    assign in_ready = r_in_ready;

    // r_out is the head entry; r_skid holds one instruction caught after a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out        <= '0;
            r_out.fmt    <= c_fmt_none;
            r_skid       <= '0;
            r_skid.fmt   <= c_fmt_none;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept)
                    r_out <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out.fmt   <= c_fmt_none;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_ill_cnt <= '0;
        else if (w_accept && w_dec.illegal && (r_ill_cnt != {ILL_CNT_W{1'b1}}))
            r_ill_cnt <= r_ill_cnt + 1'b1;
    end

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out.pc;
    assign out_rd        = r_out.rd;
    assign out_rs1       = r_out.rs1;
    assign out_rs2       = r_out.rs2;
    assign out_funct3    = r_out.funct3;
    assign out_funct7    = r_out.funct7;
    assign out_fmt       = r_out.fmt;
    assign out_imm       = r_out.imm;
    assign out_reg_write = r_out.reg_write;
    assign out_is_load   = r_out.is_load;
    assign out_is_store  = r_out.is_store;
    assign out_is_branch = r_out.is_branch;
    assign out_is_jal    = r_out.is_jal;
    assign out_is_jalr   = r_out.is_jalr;
    assign out_alu_sub   = r_out.alu_sub;
    assign out_illegal   = r_out.illegal;
    assign ill_cnt       = r_ill_cnt;

endmodule

`default_nettype wire

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Pipelined RV32I instruction decoder; the decode side of the team's instruction encoding helpers.
- Sits between the IF/ID register and the register file / execute stage.
- Accepts a 32-bit instruction and PC over a valid/ready handshake.
- Produces registered, field-split, sign-extended decode results with an illegal-instruction flag and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width for pc and imm; only 32 is supported.
- ILL_CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash the held and incoming instruction (branch redirect).
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decode result valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_funct3  out  3  funct3 field.
- out_funct7  out  7  funct7 field.
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
- out_reg_write  out  1  rd is written (R/I/U/J/JALR/LOAD and rd!=0).
- out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr  out  1 each  class flags.
- out_alu_sub  out  1  R-type funct3=000 with funct7=0100000.
- out_illegal  out  1  instruction is not a legal RV32I encoding.
- ill_cnt  out  ILL_CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset: out_valid=0, all out_* data=0, out_fmt=NONE, ill_cnt=0; in_ready=1 from the first cycle after reset.
- Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
- Latency: 1 cycle from input accept to out_valid.
- Base (no macro): single output register.
  - in_ready = !out_valid | out_ready (combinational).
  - Register loads on accept. out_valid clears when consumed with no new accept.
- Output data is held stable while out_valid & !out_ready.
- Opcodes recognised: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - I/S/B/J are sign-extended from their MSB (instr[31]).
  - U: {instr[31:12], 12'b0}.
- Illegal when any of the following holds:
  - instr[1:0] != 11, or unknown opcode.
  - R-type funct7 not in {0000000, 0100000}.
  - R-type funct7=0100000 with funct3 not in {000, 101}.
  - I-ALU funct3=001 with instr[31:25] != 0.
  - I-ALU funct3=101 with instr[31:25] not in {0000000, 0100000}.
  - LOAD funct3 in {011, 110, 111}.
  - STORE funct3 >= 011.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3 != 000.
- On illegal: out_illegal=1; all class flags, out_reg_write and out_alu_sub forced 0; out_fmt=NONE; raw fields still passed through.
- ill_cnt: +1 on each accepted illegal instruction; saturates at all-ones and never wraps.
- flush:
  - Same-cycle accept is discarded.
  - out_valid=0 next cycle.
  - ill_cnt is not incremented for an instruction discarded in the flush cycle.
- flush and rst both high: rst wins.
- Reset mid-transfer: any held result is dropped, with no partial output.

Optional Feature:
- Macro RISCV_DECODE_SKID_EN.
- Defined: a 2-entry skid buffer (main + skid register) is added.
  - in_ready is a pure register output, equal to "skid entry empty".
  - When out_ready drops, one additional accepted instruction is captured in skid.
  - Skid drains into main in order; full throughput is kept with no bubbles.
  - flush empties both entries.
- Undefined: single-register behaviour as above, with combinational in_ready.
- Port list is identical in both builds.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), pc=0x100, out_ready=1 -> next cycle: out_valid=1, rd=3, rs1=1, rs2=2, fmt=R, imm=0, reg_write=1, alu_sub=0, illegal=0, out_pc=0x100.
- SUB 0x402081B3 then ADDI x5,x0,-1 (0xFFF00293) back-to-back -> alu_sub=1; then fmt=I, imm=0xFFFFFFFF, rd=5, with no bubble between them.
- BEQ x1,x2,-4 (0xFE208EE3) -> fmt=B, is_branch=1, imm=0xFFFFFFFC, reg_write=0.
- 0x00000000 and SLLI with funct7=0100000 (0x40109093) -> illegal=1 for each, ill_cnt=2, all class flags 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; in_ready=0 (base) or one extra accept then in_ready=0 (skid); release -> both instructions delivered in order.
- flush asserted with out_valid=1 and an illegal instruction on input -> out_valid=0 next cycle, ill_cnt unchanged; rst asserted mid-stall -> out_valid=0, ill_cnt=0.
